// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: request/response bundle for both ports plus the
// dataMemory side of the arbiter.
interface dm_arbiter_if;
  logic        p0_req;
  logic        p0_rw;
  logic [31:0] p0_index;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;
  logic        p1_req;
  logic        p1_rw;
  logic [31:0] p1_index;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;
  logic        mem_active;
  logic        mem_rw;
  logic [31:0] mem_index;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  p0_req, p0_rw, p0_index, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_rw, p1_index, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_active, mem_rw, mem_index, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p0_req, p0_rw, p0_index, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_rw, p1_index, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_active, mem_rw, mem_index, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of dataMemory.
// DM_ARB_ROUND_ROBIN_EN selects round-robin tie-break, else port 0 wins.
module dm_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic        own_q, own_d;
  logic        err_q, err_d;
  logic        mem_active_q, mem_active_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_index_q, mem_index_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        p0_gnt_q, p0_gnt_d;
  logic        p1_gnt_q, p1_gnt_d;
  logic        p0_rvalid_q, p0_rvalid_d;
  logic        p1_rvalid_q, p1_rvalid_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_err_q, p1_err_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        any_req;
  logic        pick1;
  logic        in_range;
  logic [31:0] win_index;
  logic [31:0] rsp_data;
`ifdef DM_ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;
`endif

  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
`ifdef DM_ARB_ROUND_ROBIN_EN
    // last_q = 1 means port 1 was granted last
    pick1 = bus.p1_req & (~bus.p0_req | ~last_q);
    last_d = last_q;
`else
    pick1 = bus.p1_req & ~bus.p0_req;
`endif
    win_index = pick1 ? bus.p1_index : bus.p0_index;
    in_range = win_index < DEPTH_W;
    rsp_data = (mem_rw_q & ~err_q) ? bus.mem_rdata : 32'd0;

    state_d      = state_q;
    own_d        = own_q;
    err_d        = err_q;
    mem_active_d = 1'b0;
    mem_rw_d     = mem_rw_q;
    mem_index_d  = mem_index_q;
    mem_wdata_d  = mem_wdata_q;
    p0_gnt_d     = 1'b0;
    p1_gnt_d     = 1'b0;
    p0_rvalid_d  = 1'b0;
    p1_rvalid_d  = 1'b0;
    p0_err_d     = 1'b0;
    p1_err_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (any_req) begin
          state_d      = S_ACCESS;
          own_d        = pick1;
          err_d        = ~in_range;
          mem_active_d = in_range;
          mem_rw_d     = pick1 ? bus.p1_rw : bus.p0_rw;
          mem_index_d  = win_index;
          mem_wdata_d  = pick1 ? bus.p1_wdata
                               : bus.p0_wdata;
          p0_gnt_d     = ~pick1;
          p1_gnt_d     = pick1;
`ifdef DM_ARB_ROUND_ROBIN_EN
          last_d       = pick1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_RESP;
        if (own_q) begin
          p1_rvalid_d = 1'b1;
          p1_err_d    = err_q;
          p1_rdata_d  = rsp_data;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_err_d    = err_q;
          p0_rdata_d  = rsp_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      own_q        <= 1'b0;
      err_q        <= 1'b0;
      mem_active_q <= 1'b0;
      mem_rw_q     <= 1'b1;
      mem_index_q  <= 32'd0;
      mem_wdata_q  <= 32'd0;
      p0_gnt_q     <= 1'b0;
      p1_gnt_q     <= 1'b0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_rdata_q   <= 32'd0;
      p1_rdata_q   <= 32'd0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      err_q        <= err_d;
      mem_active_q <= mem_active_d;
      mem_rw_q     <= mem_rw_d;
      mem_index_q  <= mem_index_d;
      mem_wdata_q  <= mem_wdata_d;
      p0_gnt_q     <= p0_gnt_d;
      p1_gnt_q     <= p1_gnt_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.p0_gnt     = p0_gnt_q;
  assign bus.p1_gnt     = p1_gnt_q;
  assign bus.p0_rvalid  = p0_rvalid_q;
  assign bus.p1_rvalid  = p1_rvalid_q;
  assign bus.p0_err     = p0_err_q;
  assign bus.p1_err     = p1_err_q;
  assign bus.p0_rdata   = p0_rdata_q;
  assign bus.p1_rdata   = p1_rdata_q;
  assign bus.mem_active = mem_active_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_index  = mem_index_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy = (state_q == S_ACCESS) |
                    (state_q == S_WAIT);

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural
// dataMemory that answers reads in the cycle after mem_active.
module tb_dm_arbiter;

`ifdef DM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk;
  logic reset;
  dm_arbiter_if b();

  dm_arbiter #(.DEPTH(256)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (b.mem_active) begin
      if (b.mem_rw) b.mem_rdata <= mem[b.mem_index[7:0]];
      else mem[b.mem_index[7:0]] <= b.mem_wdata;
    end
  end

  int    n_total = 0;
  int    n_pass  = 0;
  logic  gq [$];
  resp_t rq [$];

  task automatic chk32(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic take_resp(logic port, logic [31:0] rdata,
                           logic err);
    resp_t r;
    if (rq.size() == 0) begin
      chk1("rvalid_unexpected", 1'b1, 1'b0);
    end else begin
      r = rq.pop_front();
      chk1("rsp_port", port, r.port);
      chk32("rsp_rdata", rdata, r.rdata);
      chk1("rsp_err", err, r.err);
    end
  endtask

  // Monitor: pops expected grants/responses whenever the DUT shows one
  always @(negedge clk) begin
    if (b.p0_gnt | b.p1_gnt) begin
      chk1("gnt_onehot", b.p0_gnt & b.p1_gnt, 1'b0);
      if (gq.size() == 0) chk1("gnt_unexpected", 1'b1, 1'b0);
      else chk1("gnt_port", b.p1_gnt, gq.pop_front());
    end
    if (b.p0_rvalid) take_resp(1'b0, b.p0_rdata, b.p0_err);
    if (b.p1_rvalid) take_resp(1'b1, b.p1_rdata, b.p1_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(logic port, logic [31:0] rdata,
                           logic err);
    resp_t r;
    r.port  = port;
    r.rdata = rdata;
    r.err   = err;
    gq.push_back(port);
    rq.push_back(r);
  endtask

  // Returns one step into the grant (ACCESS) cycle with req dropped
  task automatic issue(logic port, logic rw, logic [31:0] idx,
                       logic [31:0] wd);
    tick();
    if (port) begin
      b.p1_req = 1'b1; b.p1_rw = rw;
      b.p1_index = idx; b.p1_wdata = wd;
    end else begin
      b.p0_req = 1'b1; b.p0_rw = rw;
      b.p0_index = idx; b.p0_wdata = wd;
    end
    tick();
    b.p0_req = 1'b0;
    b.p1_req = 1'b0;
  endtask

  task automatic set_tie();
    b.p0_req = 1'b1; b.p0_rw = 1'b1; b.p0_index = 32'd2;
    b.p1_req = 1'b1; b.p1_rw = 1'b1; b.p1_index = 32'd3;
  endtask

  task automatic tie_round(logic w);
    tick();
    set_tie();
    expect_op(w, w ? 32'h5A : 32'hA5, 1'b0);
    tick();
    b.p0_req = 1'b0;
    b.p1_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_reset_state(string tag);
    chk1({tag, "_p0_gnt"}, b.p0_gnt, 1'b0);
    chk1({tag, "_p1_gnt"}, b.p1_gnt, 1'b0);
    chk1({tag, "_p0_rvalid"}, b.p0_rvalid, 1'b0);
    chk1({tag, "_p1_rvalid"}, b.p1_rvalid, 1'b0);
    chk32({tag, "_p0_rdata"}, b.p0_rdata, 32'd0);
    chk32({tag, "_p1_rdata"}, b.p1_rdata, 32'd0);
    chk1({tag, "_p0_err"}, b.p0_err, 1'b0);
    chk1({tag, "_p1_err"}, b.p1_err, 1'b0);
    chk1({tag, "_mem_active"}, b.mem_active, 1'b0);
    chk1({tag, "_mem_rw"}, b.mem_rw, 1'b1);
    chk32({tag, "_mem_index"}, b.mem_index, 32'd0);
    chk32({tag, "_mem_wdata"}, b.mem_wdata, 32'd0);
    chk1({tag, "_busy"}, b.busy, 1'b0);
  endtask

  initial begin
    b.p0_req = 0; b.p0_rw = 1; b.p0_index = 0; b.p0_wdata = 0;
    b.p1_req = 0; b.p1_rw = 1; b.p1_index = 0; b.p1_wdata = 0;
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk_reset_state("rst");
    tick();
    reset = 1'b0;

    // port 0 write idx1 = 4, then read it back
    expect_op(1'b0, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 32'd1, 32'h4);
    @(negedge clk);
    chk1("wr_active", b.mem_active, 1'b1);
    chk1("wr_rw", b.mem_rw, 1'b0);
    chk32("wr_index", b.mem_index, 32'd1);
    chk32("wr_wdata", b.mem_wdata, 32'h4);
    chk1("wr_busy", b.busy, 1'b1);
    tick();
    @(negedge clk);
    chk1("wr_wait_active", b.mem_active, 1'b0);
    tick();
    @(negedge clk);
    chk1("wr_rvalid_n3", b.p0_rvalid, 1'b1);
    chk1("wr_busy_resp", b.busy, 1'b0);

    expect_op(1'b0, 32'h4, 1'b0);
    issue(1'b0, 1'b1, 32'd1, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    chk1("rd_rvalid_n3", b.p0_rvalid, 1'b1);
    chk32("rd_rdata_n3", b.p0_rdata, 32'h4);

    // last valid index
    expect_op(1'b0, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 32'd255, 32'h77);
    @(negedge clk);
    chk1("i255_active", b.mem_active, 1'b1);
    repeat (2) tick();
    expect_op(1'b0, 32'h77, 1'b0);
    issue(1'b0, 1'b1, 32'd255, 32'd0);
    repeat (3) tick();

    // out of range on port 1, then a high-bit index on port 0
    expect_op(1'b1, 32'd0, 1'b1);
    issue(1'b1, 1'b1, 32'd256, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("oob_active", b.mem_active, 1'b0);
      if (c < 2) tick();
    end
    chk1("oob_p1_rvalid", b.p1_rvalid, 1'b1);
    chk1("oob_p1_err", b.p1_err, 1'b1);
    chk32("oob_p1_rdata", b.p1_rdata, 32'd0);
    chk1("oob_p0_rvalid", b.p0_rvalid, 1'b0);
    chk32("oob_p0_rdata_held", b.p0_rdata, 32'h77);

    expect_op(1'b0, 32'd0, 1'b1);
    issue(1'b0, 1'b0, 32'h8000_0000, 32'hDEAD);
    @(negedge clk);
    chk1("hi_active", b.mem_active, 1'b0);
    repeat (3) tick();

    // seed tie data: p0 idx2 = A5, p1 idx3 = 5A
    expect_op(1'b0, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 32'd2, 32'hA5);
    repeat (3) tick();
    expect_op(1'b1, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 32'd3, 32'h5A);
    repeat (3) tick();

    // three tie rounds; port 1 was granted last
    tie_round(1'b0);
    tie_round(RR ? 1'b1 : 1'b0);
    tie_round(1'b0);

    // port 0 holds req high: grants every third cycle
    tick();
    b.p0_req = 1'b1; b.p0_rw = 1'b1; b.p0_index = 32'd1;
    for (int r = 0; r < 3; r++) begin
      expect_op(1'b0, 32'h4, 1'b0);
      tick();
      if (r == 2) b.p0_req = 1'b0;
      @(negedge clk);
      chk1("cont_gnt", b.p0_gnt, 1'b1);
      chk1("cont_busy_acc", b.busy, 1'b1);
      tick();
      @(negedge clk);
      chk1("cont_gnt_wait", b.p0_gnt, 1'b0);
      chk1("cont_busy_wait", b.busy, 1'b1);
      tick();
      @(negedge clk);
      chk1("cont_busy_resp", b.busy, 1'b0);
      chk1("cont_rvalid", b.p0_rvalid, 1'b1);
    end
    repeat (2) tick();

    // reset during WAIT of a port 0 read aborts the response
    gq.push_back(1'b0);
    issue(1'b0, 1'b1, 32'd1, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk_reset_state("mid");
    tick();
    reset = 1'b0;
    tie_round(1'b0);

    // both ports hold req continuously
    tick();
    set_tie();
    for (int r = 0; r < 3; r++) begin
      logic w;
      w = RR ? ((r % 2) == 0) : 1'b0;
      expect_op(w, w ? 32'h5A : 32'hA5, 1'b0);
      tick();
      if (r == 2) begin
        b.p0_req = 1'b0;
        b.p1_req = 1'b0;
      end
      repeat (2) tick();
    end
    repeat (4) tick();

    chk32("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk32("rsp_queue_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
